// File: rtl/hififo_pkg.sv
// Shared types and constants for the host-to-FPGA (from PC) DMA read path.
package hififo_pkg;

  localparam int BEAT_BYTES = 8;

  // Bit positions inside the 32-bit status word
  localparam int ST_ISSUED_LSB   = 0;
  localparam int ST_DRAINED_LSB  = 8;
  localparam int ST_STRAY_BIT    = 16;
  localparam int ST_OVERFILL_BIT = 17;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PENDING,
    SLOT_FULL,
    SLOT_DRAIN
  } slot_state_e;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_REQ
  } issue_state_e;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_RUN
  } drain_state_e;

endpackage

// File: rtl/hififo_reorder_ram.sv
// Simple dual-port reorder buffer: one write port, one registered read port.
module hififo_reorder_ram
  import hififo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 64
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hififo_fpc_fifo.sv
// From-PC DMA engine: issues fixed 128-byte read requests and reorders
// out-of-order completions into an in-order 64-bit output stream.
module hififo_fpc_fifo
  import hififo_pkg::*;
#(
  parameter int NSLOTS = 4,
  parameter int BEATS  = 16,
  parameter int SW     = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [63:0]   req_addr,
  output logic          req_ack,
  output logic          rr_valid,
  output logic [63:0]   rr_addr,
  output logic [SW-1:0] rr_tag,
  output logic [4:0]    rr_count,
  input  logic          rr_ready,
  input  logic [63:0]   rx_data,
  input  logic          rx_data_valid,
  input  logic [SW-1:0] rc_tag,
  input  logic [3:0]    rc_offset,
  input  logic          rc_last,
  output logic [63:0]   o_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [31:0]   status,
  output logic          interrupt
);

  localparam int         AW       = SW + 4;
  localparam logic [4:0] FULL_CNT = 5'(BEATS);
  localparam logic [3:0] LAST_OFF = 4'(BEATS - 1);

  // Handshakes: a transfer happens on the rising clock edge where valid and
  // ready are both high; valid never waits on ready, and payload is held
  // stable while valid is high and ready is low.

  slot_state_e   slot_state [NSLOTS];
  logic [4:0]    slot_cnt   [NSLOTS];
  logic [SW-1:0] alloc_ptr;
  logic [SW-1:0] drain_ptr;

  issue_state_e  issue_state, issue_next;
  logic          issue_load, issue_accept;

  drain_state_e  drain_state, drain_next;
  logic          drain_start, drain_done;
  logic [4:0]    rd_off;
  logic [3:0]    out_cnt;
  logic          rd_en, rd_pend;
  logic [63:0]   ram_rdata;
  logic [63:0]   ob_data [2];
  logic          ob_wp, ob_rp;
  logic [1:0]    ob_cnt;
  logic          pop;
  logic [2:0]    occ_after;

  logic          beat_stray, beat_over, beat_ok;
  logic [7:0]    issued_cnt, drained_cnt;
  logic          err_stray, err_overfill;

  logic          unused_rc_last;
  assign unused_rc_last = rc_last;

  // ---------------- issue FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_state <= ISSUE_IDLE;
      rr_addr     <= '0;
      rr_tag      <= '0;
    end else begin
      issue_state <= issue_next;
      if (issue_load) begin
        rr_addr <= req_addr;
        rr_tag  <= alloc_ptr;
      end
    end
  end

  always_comb begin
    issue_next   = issue_state;
    issue_load   = 1'b0;
    issue_accept = 1'b0;
    case (issue_state)
      ISSUE_IDLE: begin
        if (req_valid && slot_state[alloc_ptr] == SLOT_FREE) begin
          issue_load = 1'b1;
          issue_next = ISSUE_REQ;
        end
      end
      ISSUE_REQ: begin
        if (rr_ready) begin
          issue_accept = 1'b1;
          issue_next   = ISSUE_IDLE;
        end
      end
      default: issue_next = ISSUE_IDLE;
    endcase
  end

  assign rr_valid = (issue_state == ISSUE_REQ);
  assign req_ack  = issue_accept;
  assign rr_count = FULL_CNT;

  // ---------------- completion classification ----------------
  always_comb begin
    beat_stray = rx_data_valid &&
                 (slot_state[rc_tag] == SLOT_FREE || slot_state[rc_tag] == SLOT_DRAIN);
    beat_over  = rx_data_valid && !beat_stray && (slot_cnt[rc_tag] == FULL_CNT);
    beat_ok    = rx_data_valid && !beat_stray && !beat_over;
  end

  // ---------------- drain FSM ----------------
  assign o_valid   = (ob_cnt != 2'd0);
  assign o_data    = ob_data[ob_rp];
  assign pop       = o_valid && o_ready;
  // Output-buffer occupancy after this cycle; a read is launched only when
  // its result is sure to find a free entry one cycle later.
  assign occ_after = 3'(ob_cnt) + 3'(rd_pend) - 3'(pop);

  always_comb begin
    drain_next  = drain_state;
    drain_start = 1'b0;
    drain_done  = 1'b0;
    rd_en       = 1'b0;
    case (drain_state)
      DRAIN_IDLE: begin
        if (slot_state[drain_ptr] == SLOT_FULL) begin
          drain_start = 1'b1;
          drain_next  = DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        rd_en = (rd_off != FULL_CNT) && (occ_after < 3'd2);
        if (pop && out_cnt == LAST_OFF) begin
          drain_done = 1'b1;
          drain_next = DRAIN_IDLE;
        end
      end
      default: drain_next = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_state <= DRAIN_IDLE;
      drain_ptr   <= '0;
      rd_off      <= '0;
      out_cnt     <= '0;
      rd_pend     <= 1'b0;
      ob_wp       <= 1'b0;
      ob_rp       <= 1'b0;
      ob_cnt      <= '0;
      interrupt   <= 1'b0;
    end else begin
      drain_state <= drain_next;
      rd_pend     <= rd_en;
      interrupt   <= drain_done;
      ob_cnt      <= occ_after[1:0];
      if (drain_start) begin
        rd_off  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_en) rd_off  <= rd_off + 5'd1;
        if (pop)   out_cnt <= out_cnt + 4'd1;
      end
      if (drain_done) drain_ptr <= drain_ptr + SW'(1);
      if (rd_pend)    ob_wp     <= ~ob_wp;
      if (pop)        ob_rp     <= ~ob_rp;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_pend) ob_data[ob_wp] <= ram_rdata;
  end

  // ---------------- slot bookkeeping and status ----------------
  // Issue, completion and drain each act only on a slot in a distinct state,
  // so they never target the same slot in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_cnt[i]   <= '0;
      end
      alloc_ptr    <= '0;
      issued_cnt   <= '0;
      drained_cnt  <= '0;
      err_stray    <= 1'b0;
      err_overfill <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        if (issue_accept && alloc_ptr == SW'(i)) slot_state[i] <= SLOT_PENDING;
        if (beat_ok && rc_tag == SW'(i)) begin
          slot_cnt[i] <= slot_cnt[i] + 5'd1;
          if (slot_cnt[i] == FULL_CNT - 5'd1) slot_state[i] <= SLOT_FULL;
        end
        if (drain_start && drain_ptr == SW'(i)) slot_state[i] <= SLOT_DRAIN;
        if (drain_done && drain_ptr == SW'(i)) begin
          slot_state[i] <= SLOT_FREE;
          slot_cnt[i]   <= '0;
        end
      end
      if (issue_accept) begin
        alloc_ptr  <= alloc_ptr + SW'(1);
        issued_cnt <= issued_cnt + 8'd1;
      end
      if (drain_done) drained_cnt  <= drained_cnt + 8'd1;
      if (beat_stray) err_stray    <= 1'b1;
      if (beat_over)  err_overfill <= 1'b1;
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_ISSUED_LSB +: 8]   = issued_cnt;
    status[ST_DRAINED_LSB +: 8]  = drained_cnt;
    status[ST_STRAY_BIT]         = err_stray;
    status[ST_OVERFILL_BIT]      = err_overfill;
  end

  hififo_reorder_ram #(
    .DEPTH(NSLOTS * BEATS),
    .AW   (AW),
    .W    (64)
  ) u_ram (
    .clock(clock),
    .we   (beat_ok),
    .waddr({rc_tag, rc_offset}),
    .wdata(rx_data),
    .re   (rd_en),
    .raddr({drain_ptr, rd_off[3:0]}),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_hififo_fpc_fifo.sv
// Bench for hififo_fpc_fifo: output must be every issued request's 16 beats,
// in issue order, whatever order the completion beats arrive in.
module tb_hififo_fpc_fifo;

  localparam int NSLOTS = 4;
  localparam int BEATS  = 16;
  localparam int SW     = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [63:0]   req_addr = '0;
  logic          req_ack;
  logic          rr_valid;
  logic [63:0]   rr_addr;
  logic [SW-1:0] rr_tag;
  logic [4:0]    rr_count;
  logic          rr_ready = 1'b0;
  logic [63:0]   rx_data = '0;
  logic          rx_data_valid = 1'b0;
  logic [SW-1:0] rc_tag = '0;
  logic [3:0]    rc_offset = '0;
  logic          rc_last = 1'b0;
  logic [63:0]   o_data;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [31:0]   status;
  logic          interrupt;

  hififo_fpc_fifo #(.NSLOTS(NSLOTS), .BEATS(BEATS), .SW(SW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ack(req_ack),
    .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_tag(rr_tag), .rr_count(rr_count),
    .rr_ready(rr_ready),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rc_tag(rc_tag),
    .rc_offset(rc_offset), .rc_last(rc_last),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .status(status), .interrupt(interrupt)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] tag_data [NSLOTS][BEATS];
  int          n_issued = 0;
  int          n_beats  = 0;
  int          n_irq    = 0;
  int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  logic        stall_q  = 1'b0;
  logic        gap_q    = 1'b0;
  logic [63:0] stall_data = '0;
  logic [63:0] mon_exp;
  int          tags [5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output side: drives o_ready, checks every accepted beat against exp_q.
  always @(negedge clock) begin
    if (reset) begin
      stall_q = 1'b0;
      gap_q   = 1'b0;
    end else begin
      if (rdy_mode == 0)      o_ready = 1'b1;
      else if (rdy_mode == 1) o_ready = ($urandom_range(0, 2) != 0);
      else                    o_ready = 1'b0;
      if (stall_q) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, stall_data);
      end
      if (gap_q && rdy_mode == 0) check("no_gap", o_valid, 1);
      gap_q = 1'b0;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", o_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("o_data", o_data, mon_exp);
        end
        n_beats++;
        gap_q = ((n_beats % BEATS) != 0);
      end
      stall_q    = o_valid && !o_ready;
      stall_data = o_data;
      if (interrupt) n_irq++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input logic [63:0] addr);
    int tag;
    int budget;
    tag = n_issued % NSLOTS;
    for (int k = 0; k < BEATS; k++) begin
      tag_data[tag][k] = {$urandom, $urandom};
      exp_q.push_back(tag_data[tag][k]);
    end
    req_addr  = addr;
    req_valid = 1'b1;
    budget    = 0;
    while (!rr_valid && budget < 400) begin
      @(negedge clock);
      budget++;
    end
    check("rr_valid_timeout", rr_valid, 1);
    check("rr_addr", rr_addr, addr);
    check("rr_tag", rr_tag, tag);
    check("rr_count", rr_count, BEATS);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clock);
      check("rr_hold_addr", rr_addr, addr);
      check("req_ack_early", req_ack, 0);
    end
    rr_ready = 1'b1;
    #1;
    check("req_ack", req_ack, 1);
    @(negedge clock);
    rr_ready  = 1'b0;
    req_valid = 1'b0;
    n_issued++;
    check("req_ack_pulse", req_ack, 0);
  endtask

  task automatic send_beat(input int tag, input int off, input logic [63:0] data, input logic last);
    @(negedge clock);
    rx_data_valid = 1'b1;
    rc_tag        = SW'(tag);
    rc_offset     = 4'(off);
    rx_data       = data;
    rc_last       = last;
  endtask

  task automatic rx_idle();
    @(negedge clock);
    rx_data_valid = 1'b0;
    rc_last       = 1'b0;
  endtask

  task automatic send_range(input int tag, input int first, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clock);
        rx_data_valid = 1'b0;
      end
      send_beat(tag, first + k, tag_data[tag][first + k], (k == n - 1));
    end
    rx_idle();
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((exp_q.size() != 0 || o_valid) && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    check("drain_timeout", (exp_q.size() == 0), 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_counts(input string tag, input logic [1:0] err);
    check({tag, "_issued"}, status[7:0], 8'(n_issued));
    check({tag, "_drained"}, status[15:8], 8'(n_beats / BEATS));
    check({tag, "_irq"}, n_irq, n_beats / BEATS);
    check({tag, "_err"}, status[17:16], err);
    check({tag, "_hi"}, status[31:18], 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order [4];
    int n, j, s, t, tmp, base, budget;
    logic [63:0] addr;

    repeat (3) @(negedge clock);
    check("rst_rr_valid", rr_valid, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_status", status, 0);
    reset = 1'b0;
    @(negedge clock);

    // single request, in-order completion
    issue_req(64'h1000);
    send_range(0, 0, BEATS, 1'b0);
    wait_idle();
    check_counts("t1", 2'b00);

    // four requests, completions in order 3,1,0,2, two TLPs each
    for (int i = 0; i < 4; i++) begin
      tags[i] = n_issued % NSLOTS;
      issue_req(64'(i * 128));
    end
    order = '{3, 1, 0, 2};
    for (int i = 0; i < 4; i++) begin
      send_range(tags[order[i]], 0, 8, 1'b0);
      send_range(tags[order[i]], 8, 8, 1'b0);
    end
    wait_idle();
    check_counts("t2", 2'b00);

    // all slots pending: a fifth request must stall until the oldest drains
    for (int i = 0; i < 4; i++) begin
      tags[i] = n_issued % NSLOTS;
      issue_req(64'h8000 + 64'(i * 128));
    end
    req_addr  = 64'h5000;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("full_rr_valid", rr_valid, 0);
      check("full_req_ack", req_ack, 0);
    end
    send_range(tags[0], 0, BEATS, 1'b0);
    tags[4] = n_issued % NSLOTS;
    check("fifth_tag_is_oldest", tags[4], tags[0]);
    issue_req(64'h5000);
    for (int i = 1; i < 5; i++) send_range(tags[i], 0, BEATS, 1'b1);
    wait_idle();
    check_counts("t3", 2'b00);

    // random o_ready, random completion order and split points
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        order[i] = n_issued % NSLOTS;
        addr = {$urandom, $urandom} & ~64'h7F;
        issue_req(addr);
      end
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < n; i++) begin
        s = $urandom_range(1, BEATS - 1);
        send_range(order[i], s, BEATS - s, 1'b1);
        send_range(order[i], 0, s, 1'b1);
      end
      wait_idle();
      check_counts("t4", 2'b00);
    end
    rdy_mode = 0;

    // stray beat to a FREE slot: error flag, no output
    send_beat(2, 5, 64'hDEAD_BEEF_0000_0002, 1'b1);
    rx_idle();
    repeat (20) @(negedge clock);
    check("stray_no_output", exp_q.size(), 0);
    check_counts("t5a", 2'b01);

    // 17th beat to a FULL slot: overfill flag, buffered data untouched
    t = n_issued % NSLOTS;
    issue_req(64'h6000);
    for (int k = 0; k < BEATS; k++) send_beat(t, k, tag_data[t][k], (k == BEATS - 1));
    send_beat(t, 3, ~tag_data[t][3], 1'b1);
    rx_idle();
    wait_idle();
    check_counts("t5b", 2'b11);

    // reset in the middle of a drain with a request waiting on rr_ready
    t = n_issued % NSLOTS;
    issue_req(64'h3000);
    send_range(t, 0, BEATS, 1'b0);
    req_addr  = 64'h4000;
    req_valid = 1'b1;
    base   = n_beats;
    budget = 0;
    while (n_beats < base + 7 && budget < 500) begin
      @(negedge clock);
      budget++;
    end
    check("mid_drain_timeout", (n_beats >= base + 7), 1);
    check("pre_rst_o_valid", o_valid, 1);
    check("pre_rst_rr_valid", rr_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_o_valid", o_valid, 0);
    check("async_rst_rr_valid", rr_valid, 0);
    check("async_rst_interrupt", interrupt, 0);
    check("async_rst_status", status, 0);
    req_valid = 1'b0;
    exp_q.delete();
    n_issued = 0;
    n_beats  = 0;
    n_irq    = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_status", status, 0);
    issue_req(64'h2000);
    send_range(0, 0, BEATS, 1'b1);
    wait_idle();
    check_counts("t6", 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hififo_fpc_fifo.md
Name: hififo_fpc_fifo

Overview:
- Host-to-FPGA ("from PC") DMA engine; the counterpart of the to-PC write path.
- Takes 64-bit host addresses from the descriptor fetcher, issues 128-byte PCIe read requests and accepts read-completion beats that may arrive out of order.
- Reassembles completions into an in-order 64-bit stream for user logic.
- Single clock domain; any user-clock crossing is done by a downstream fwft_fifo.

Parameters:
- NSLOTS, 4, number of outstanding read requests / reorder slots; power of 2, 2..8.
- BEATS, 16, 64-bit beats per request (128 bytes); fixed-size requests.
- SW, 2, slot index width, log2(NSLOTS).

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  descriptor fetcher has a request address
- req_addr  in  64  host byte address, 128-byte aligned
- req_ack  out  1  one-cycle pulse; request address consumed
- rr_valid  out  1  read request to PCIe TX
- rr_addr  out  64  read request address
- rr_tag  out  SW  tag equal to allocated slot index
- rr_count  out  5  request length in beats, constant BEATS
- rr_ready  in  1  TX accepts read request
- rx_data  in  64  completion payload beat
- rx_data_valid  in  1  completion beat valid
- rc_tag  in  SW  tag of current completion beat
- rc_offset  in  4  beat offset within the request for this beat
- rc_last  in  1  final beat of the completion TLP (informational; not used for counting)
- o_data  out  64  in-order output stream
- o_valid  out  1  o_data valid
- o_ready  in  1  downstream accepts
- status  out  32  [7:0] requests issued mod 256, [15:8] slots drained mod 256, [16] sticky stray-completion error, [17] sticky overfill error, [31:18] 0
- interrupt  out  1  one-cycle pulse per drained slot

Behaviour:
- Reset (async assert, sync release): all slots FREE; alloc and drain pointers 0; rr_valid, req_ack, o_valid, interrupt 0; status 0.
- Slot state: FREE -> PENDING (request accepted) -> FULL (beat count reaches BEATS) -> DRAIN -> FREE.
- Per-slot counter is 5 bits; a request is complete at count == 16.
- Issue FSM:
  - IDLE: if req_valid and slot[alloc] FREE, latch req_addr into rr_addr, set rr_tag = alloc, assert rr_valid, go to REQ.
  - REQ: rr_valid held with rr_addr/rr_tag stable until rr_ready. The cycle rr_valid && rr_ready: slot[alloc] becomes PENDING, alloc++ (wraps mod NSLOTS), req_ack pulses, return to IDLE.
  - Back-to-back requests: at most one every 2 cycles.
- Completion write:
  - Each rx_data_valid beat writes the buffer RAM (NSLOTS*BEATS x 64, simple dual port) at address {rc_tag, rc_offset} and increments slot[rc_tag] count.
  - Beat to a FREE or DRAIN slot: RAM write and count suppressed, status[16] set.
  - Beat to a slot already at count 16: RAM write and count suppressed, status[17] set.
- Drain FSM:
  - Starts when slot[drain] is FULL; reads RAM sequentially with 1-cycle RAM latency; presents beats 0..15 in offset order.
  - AXI-style handshake: o_data stable while o_valid && !o_ready. Prefetch register so full throughput (1 beat/cycle) is sustained when o_ready is held high.
  - After beat 15 is accepted: slot becomes FREE, count cleared, drain++, interrupt pulses, status[15:8]++.
- Simultaneous events:
  - Issue allocating a slot in the same cycle the drain frees it: the allocation sees FREE only from the next cycle; no same-cycle bypass.
  - Completion beat and drain read to different slots in the same cycle: both proceed.
- Wrap-around: alloc == drain with all slots non-FREE means full; issue stalls in IDLE with req_ack low.
- Reset mid-operation: everything is dropped. Completions for pre-reset tags are undetectable; they are written only if the slot has since become PENDING. Software must quiesce DMA before reset.

Decomposition:
- Shared package hififo_pkg:
  - constant BEAT_BYTES = 8
  - slot state enum {FREE, PENDING, FULL, DRAIN}
  - status bit-position constants
- Sub-module hififo_reorder_ram: simple dual-port RAM, registered read, NSLOTS*BEATS x 64, inferrable as block RAM.

Test Plan:
- Single request, addr 0x1000: completion beats in order, tag 0 -> rr_addr 0x1000, rr_tag 0; o_data emits 16 beats in order; interrupt pulses once; status[7:0] = 1, status[15:8] = 1.
- Four requests at 0x0, 0x80, 0x100, 0x180: completions returned in tag order 3, 1, 0, 2, each split into two 8-beat TLPs -> output is exactly addr order, 64 beats, no gaps while o_ready = 1.
- Fifth req_valid while all 4 slots are PENDING -> req_ack stays low and rr_valid stays 0 until slot 0 drains; then rr_tag = 0.
- o_ready toggled at random during drain -> every beat emitted once, o_data stable under stall, final beat count 16 per slot.
- Beat with rc_tag = 2 while slot 2 is FREE -> status[16] = 1, no output. A 17th beat to a FULL slot -> status[17] = 1, data unchanged.
- Assert reset mid-drain at beat 7 -> o_valid, rr_valid and interrupt drop asynchronously; after release, status = 0 and a fresh request completes normally with tag 0.
